// File: rtl/debug_cmd_rx.sv
// rtl/debug_cmd_rx.sv - PC->FPGA debug link command receiver: frame hunt, checksum verify, payload stream
module debug_cmd_rx #(
    parameter logic [7:0]  START_BYTE = 8'h68,
    parameter int unsigned MAX_LEN    = 16,
    parameter logic [31:0] TIMEOUT    = 32'd4095
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rdata,
    input  logic       i_rready,
    output logic       o_rreq,
    output logic       o_cmd_valid,
    output logic [7:0] o_cmd,
    output logic [7:0] o_len,
    output logic       o_dvalid,
    output logic [7:0] o_data,
    output logic       o_dlast,
    input  logic       i_dready,
    output logic       o_err,
    output logic [1:0] o_err_code,
    output logic [7:0] o_err_cnt
);

    localparam int unsigned IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH     = 1 << IW;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CMD     = 3'd1;
    localparam logic [2:0] LEN     = 3'd2;
    localparam logic [2:0] PAYLOAD = 3'd3;
    localparam logic [2:0] CHK     = 3'd4;
    localparam logic [2:0] DRAIN   = 3'd5;

    logic [2:0]  state;
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [7:0]  chk;
    logic [7:0]  idx;
    logic [31:0] tmo;
    logic [7:0]  buf_mem [DEPTH];

    logic       pop;
    logic       mid_frame;
    logic       expire;
    logic       err_fire;
    logic [1:0] err_code_n;

    // o_rreq is the pop strobe: the byte on i_rdata is consumed at the end of its cycle
    always_comb begin
        pop        = o_rreq;
        mid_frame  = (state == CMD) || (state == LEN) || (state == PAYLOAD) || (state == CHK);
        expire     = mid_frame && (tmo == 32'd1);
        err_fire   = 1'b0;
        err_code_n = 2'd0;
        if (expire) begin
            err_fire   = 1'b1;
            err_code_n = 2'd3;
        end else if (pop && (state == LEN) && (i_rdata > MAX_LEN_B)) begin
            err_fire   = 1'b1;
            err_code_n = 2'd1;
        end else if (pop && (state == CHK) && (i_rdata != chk)) begin
            err_fire   = 1'b1;
            err_code_n = 2'd2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (pop && (state == PAYLOAD) && !expire) begin
            buf_mem[idx[IW-1:0]] <= i_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cmd         <= 8'd0;
            len         <= 8'd0;
            chk         <= 8'd0;
            idx         <= 8'd0;
            tmo         <= TIMEOUT;
            o_rreq      <= 1'b0;
            o_cmd_valid <= 1'b0;
            o_cmd       <= 8'd0;
            o_len       <= 8'd0;
            o_dvalid    <= 1'b0;
            o_data      <= 8'd0;
            o_dlast     <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= 2'd0;
            o_err_cnt   <= 8'd0;
        end else begin
            o_rreq      <= i_rready && !o_rreq && (state != DRAIN);
            o_cmd_valid <= 1'b0;
            o_err       <= 1'b0;

            if (!mid_frame || expire || pop) begin
                tmo <= TIMEOUT;
            end else begin
                tmo <= tmo - 32'd1;
            end

            if (err_fire) begin
                o_err      <= 1'b1;
                o_err_code <= err_code_n;
                if (o_err_cnt != 8'hFF) begin
                    o_err_cnt <= o_err_cnt + 8'd1;
                end
            end

            if (expire) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop && (i_rdata == START_BYTE)) state <= CMD;
                    end
                    CMD: begin
                        if (pop) begin
                            cmd   <= i_rdata;
                            chk   <= i_rdata;
                            state <= LEN;
                        end
                    end
                    LEN: begin
                        if (pop) begin
                            len <= i_rdata;
                            chk <= chk ^ i_rdata;
                            idx <= 8'd0;
                            if (i_rdata > MAX_LEN_B)  state <= IDLE;
                            else if (i_rdata == 8'd0) state <= CHK;
                            else                      state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (pop) begin
                            chk <= chk ^ i_rdata;
                            idx <= idx + 8'd1;
                            if ((idx + 8'd1) == len) state <= CHK;
                        end
                    end
                    CHK: begin
                        if (pop) begin
                            if (i_rdata == chk) begin
                                state       <= DRAIN;
                                o_cmd_valid <= 1'b1;
                                o_cmd       <= cmd;
                                o_len       <= len;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    DRAIN: begin
                        // o_cmd_valid is high only in the first DRAIN cycle
                        if (o_cmd_valid) begin
                            if (len == 8'd0) begin
                                state <= IDLE;
                            end else begin
                                o_dvalid <= 1'b1;
                                o_data   <= buf_mem[0];
                                o_dlast  <= (len == 8'd1);
                                idx      <= 8'd1;
                            end
                        end else if (o_dvalid && i_dready) begin
                            if (o_dlast) begin
                                o_dvalid <= 1'b0;
                                o_dlast  <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                o_data  <= buf_mem[idx[IW-1:0]];
                                o_dlast <= (idx == (len - 8'd1));
                                idx     <= idx + 8'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
